// File: rtl/bubble_pkg.sv
// rtl/bubble_pkg.sv - shared types, defaults and score table for the hit handler
package bubble_pkg;

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        IMMORTAL = 2'd1,
        OVER     = 2'd2
    } hit_state_t;

    typedef logic [1:0] ball_type_t;

    localparam int LIVES_INIT_DEFAULT      = 3;
    localparam int IMMORTAL_FRAMES_DEFAULT = 90;

    // Points awarded per ball type 0..3 when the rope splits a ball
    localparam int unsigned SCORE_TBL [4] = '{50, 100, 200, 400};

endpackage

// File: rtl/frame_event_latch.sv
// rtl/frame_event_latch.sv - per-frame sticky collision flags with first rope-hit type capture
import bubble_pkg::*;

module frame_event_latch (
    input  logic       clk,
    input  logic       reset,
    input  logic       sof,
    input  logic       clear,
    input  logic       col_player_ball,
    input  logic       col_rope_ball,
    input  ball_type_t col_ball_type,
    input  logic       col_present,
    output logic       hit_f,
    output logic       rope_f,
    output logic       pres_f,
    output ball_type_t rope_t
);

    // Accumulate flags over a frame; on sof restart from this cycle's inputs,
    // since a collision in the sof cycle belongs to the new frame
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            hit_f  <= 1'b0;
            rope_f <= 1'b0;
            pres_f <= 1'b0;
            rope_t <= '0;
        end else if (sof) begin
            hit_f  <= col_player_ball;
            rope_f <= col_rope_ball;
            pres_f <= col_present;
            rope_t <= col_rope_ball ? col_ball_type : '0;
        end else begin
            hit_f  <= hit_f  | col_player_ball;
            rope_f <= rope_f | col_rope_ball;
            pres_f <= pres_f | col_present;
            if (col_rope_ball && !rope_f) begin
                rope_t <= col_ball_type;
            end
        end
    end

endmodule

// File: rtl/hit_handler.sv
// rtl/hit_handler.sv - frame-based hit resolution: lives, immortality, splits, score (HIT_HANDLER_SCORE_EN enables score)
import bubble_pkg::*;

module hit_handler #(
    parameter int LIVES_INIT      = LIVES_INIT_DEFAULT,
    parameter int LIFE_W          = 3,
    parameter int IMMORTAL_FRAMES = IMMORTAL_FRAMES_DEFAULT,
    parameter int IMM_W           = 7,
    parameter int SCORE_W         = 14
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic               game_restart,
    input  logic               col_player_ball,
    input  logic               col_rope_ball,
    input  logic [1:0]         col_ball_type,
    input  logic               col_present,
    output logic               immortal,
    output logic [LIFE_W-1:0]  lives,
    output logic               player_hit,
    output logic               split_req,
    output logic [1:0]         split_type,
    output logic               present_taken,
    output logic               game_over,
    output logic [SCORE_W-1:0] score
);

    hit_state_t        state;
    logic [IMM_W-1:0]  imm_cnt;
    logic              hit_f;
    logic              rope_f;
    logic              pres_f;
    ball_type_t        rope_t;

    frame_event_latch u_latch (
        .clk             (clk),
        .reset           (reset),
        .sof             (startOfFrame),
        .clear           (game_restart),
        .col_player_ball (col_player_ball),
        .col_rope_ball   (col_rope_ball),
        .col_ball_type   (col_ball_type),
        .col_present     (col_present),
        .hit_f           (hit_f),
        .rope_f          (rope_f),
        .pres_f          (pres_f),
        .rope_t          (rope_t)
    );

    // Game FSM: resolves last frame's flags on startOfFrame; outputs registered
    always_ff @(posedge clk) begin
        if (reset || game_restart) begin
            state         <= PLAY;
            lives         <= LIFE_W'(LIVES_INIT);
            imm_cnt       <= '0;
            immortal      <= 1'b0;
            game_over     <= 1'b0;
            player_hit    <= 1'b0;
            split_req     <= 1'b0;
            present_taken <= 1'b0;
            split_type    <= '0;
        end else begin
            player_hit    <= 1'b0;
            split_req     <= 1'b0;
            present_taken <= 1'b0;
            if (startOfFrame) begin
                case (state)
                    PLAY: begin
                        // A present shields the player from a same-frame ball hit
                        if (pres_f) begin
                            present_taken <= 1'b1;
                            imm_cnt       <= IMM_W'(IMMORTAL_FRAMES);
                            state         <= IMMORTAL;
                            immortal      <= 1'b1;
                        end else if (hit_f) begin
                            player_hit <= 1'b1;
                            if (lives > LIFE_W'(1)) begin
                                lives    <= lives - LIFE_W'(1);
                                imm_cnt  <= IMM_W'(IMMORTAL_FRAMES);
                                state    <= IMMORTAL;
                                immortal <= 1'b1;
                            end else begin
                                lives     <= '0;
                                state     <= OVER;
                                game_over <= 1'b1;
                            end
                        end
                    end
                    IMMORTAL: begin
                        // A new present restarts the window rather than extending it
                        if (pres_f) begin
                            present_taken <= 1'b1;
                            imm_cnt       <= IMM_W'(IMMORTAL_FRAMES);
                        end else if (imm_cnt <= IMM_W'(1)) begin
                            imm_cnt  <= '0;
                            state    <= PLAY;
                            immortal <= 1'b0;
                        end else begin
                            imm_cnt <= imm_cnt - IMM_W'(1);
                        end
                    end
                    OVER: begin
                        game_over <= 1'b1;
                    end
                    default: begin
                        state     <= PLAY;
                        immortal  <= 1'b0;
                        game_over <= 1'b0;
                    end
                endcase
                if (state != OVER && rope_f) begin
                    split_req  <= 1'b1;
                    split_type <= rope_t;
                end
            end
        end
    end

`ifdef HIT_HANDLER_SCORE_EN
    logic [SCORE_W:0] score_sum;

    assign score_sum = {1'b0, score} + {1'b0, SCORE_W'(SCORE_TBL[split_type])};

    // Add the split ball's value during the split_req cycle, saturating at all-ones
    always_ff @(posedge clk) begin
        if (reset || game_restart) begin
            score <= '0;
        end else if (split_req) begin
            score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
        end
    end
`else
    assign score = '0;
`endif

endmodule
